// File: rtl/fifo_credit_tx.sv
// fifo_credit_tx: producer-side credit transmitter feeding a remote FWFT FIFO.
// Ports: clk/reset (sync, active-high); write side if_full_n/if_write_ce/
//   if_write/if_din; registered link link_valid/link_data; credit_in pulses
//   from the remote reader; flush/flush_done drain handshake; credit_count
//   holds the current credits.
// Optional: define CREDIT_CHECK_EN to build the sticky over-return detector
//   that drives credit_err; otherwise credit_err is tied low.
module fifo_credit_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CREDITS    = 32,
    parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    input  logic                  credit_in,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  credit_count,
    output logic                  credit_err
);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] CRED_ONE = CNT_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;
    logic                  accept;
    logic                  at_max;
    logic                  drained;

    assign if_full_n = (state_q == S_RUN) && (cnt_q != '0);
    assign accept    = if_write & if_write_ce & if_full_n;
    assign at_max    = (cnt_q == CRED_MAX);
    // Every credit home and nothing on the wire this cycle.
    assign drained   = at_max && !valid_q;

    // Saturating credit update; a return at full count is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = CRED_MAX;
        end else if (accept && !credit_in) begin
            cnt_d = cnt_q - CRED_ONE;
        end else if (!accept && credit_in && !at_max) begin
            cnt_d = cnt_q + CRED_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (flush) state_d = S_FLUSH;
            S_FLUSH: begin
                if (!flush) begin
                    state_d = S_RUN;
                end else if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  if (!flush) state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= accept;
            if (accept) begin
                data_q <= if_din;
            end
            done_q  <= (state_d == S_DONE);
        end
    end

    assign link_valid   = valid_q;
    assign link_data    = data_q;
    assign flush_done   = done_q;
    assign credit_count = cnt_q;

`ifdef CREDIT_CHECK_EN
    logic err_q;
    logic over_return;

    // Credits arriving before the counter is loaded, or beyond the
    // remote depth, mean the two ends disagree on what is in flight.
    assign over_return = credit_in &&
                         ((state_q == S_INIT) || (at_max && !accept));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (over_return) begin
            err_q <= 1'b1;
        end
    end

    assign credit_err = err_q;
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_credit_tx.sv
// tb_fifo_credit_tx: directed plus randomized check of fifo_credit_tx
// against a cycle-level behavioural model of the credit link.
module tb_fifo_credit_tx;

    localparam int DW = 32;
    localparam int CR = 4;
    localparam int CW = $clog2(CR + 1);

`ifdef CREDIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_full_n;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          credit_in = 1'b0;
    logic          flush = 1'b0;
    logic          flush_done;
    logic [CW-1:0] credit_count;
    logic          credit_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    fifo_credit_tx #(
        .DATA_WIDTH(DW),
        .CREDITS   (CR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_full_n   (if_full_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .link_valid  (link_valid),
        .link_data   (link_data),
        .credit_in   (credit_in),
        .flush       (flush),
        .flush_done  (flush_done),
        .credit_count(credit_count),
        .credit_err  (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: phases of the link and a plain credit integer.
    localparam int P_WAKE  = 0;
    localparam int P_OPEN  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_IDLE  = 3;

    int            m_phase = P_WAKE;
    int            m_cred  = 0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    bit            m_err   = 1'b0;
    bit            m_acc;
    bit            m_quiet;
    int            m_nxt;

    function automatic bit m_open();
        return (m_phase == P_OPEN) && (m_cred > 0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = P_WAKE;
            m_cred  = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
        end else begin
            m_acc   = if_write && if_write_ce && m_open();
            m_quiet = (m_cred == CR) && !m_valid;
            if (m_phase == P_WAKE) begin
                if (credit_in && CHK) m_err = 1'b1;
                m_cred  = CR;
                m_phase = P_OPEN;
            end else begin
                m_nxt = m_cred - int'(m_acc) + int'(credit_in);
                if (m_nxt > CR) begin
                    m_nxt = CR;
                    if (CHK) m_err = 1'b1;
                end
                m_cred = m_nxt;
                case (m_phase)
                    P_OPEN:  if (flush) m_phase = P_DRAIN;
                    P_DRAIN: begin
                        if (!flush) m_phase = P_OPEN;
                        else if (m_quiet) m_phase = P_IDLE;
                    end
                    default: if (!flush) m_phase = P_OPEN;
                endcase
            end
            m_valid = m_acc;
            if (m_acc) m_data = if_din;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("full_n", 64'(if_full_n), 64'(m_open()));
            chk("valid", 64'(link_valid), 64'(m_valid));
            chk("data", 64'(link_data), 64'(m_data));
            chk("count", 64'(credit_count), 64'(m_cred));
            chk("done", 64'(flush_done), 64'(m_phase == P_IDLE));
            chk("err", 64'(credit_err), 64'(m_err));
        end
    end

    int hold;

    initial begin
        reset = 1'b1;
        step();
        started = 1'b1;
        step();
        step();
        chk("rst_full_n", 64'(if_full_n), 64'd0);
        chk("rst_valid", 64'(link_valid), 64'd0);
        chk("rst_count", 64'(credit_count), 64'd0);
        chk("rst_done", 64'(flush_done), 64'd0);
        reset = 1'b0;
        chk("init_full_n", 64'(if_full_n), 64'd0);
        step();
        chk("run_full_n", 64'(if_full_n), 64'd1);
        chk("run_count", 64'(credit_count), 64'd4);

        if_write    = 1'b1;
        if_write_ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_din = 32'hA0 + 32'(i);
            step();
            chk("burst_valid", 64'(link_valid), 64'd1);
            chk("burst_data", 64'(link_data), 64'hA0 + 64'(i));
            chk("burst_count", 64'(credit_count), 64'(3 - i));
        end
        chk("empty_full_n", 64'(if_full_n), 64'd0);
        if_din = 32'hA4;
        step();
        chk("blocked_valid", 64'(link_valid), 64'd0);
        chk("blocked_data", 64'(link_data), 64'hA3);

        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        chk("one_cred", 64'(credit_count), 64'd1);
        if_din = 32'hB0;
        step();
        chk("one_valid", 64'(link_valid), 64'd1);
        chk("one_data", 64'(link_data), 64'hB0);
        chk("one_count", 64'(credit_count), 64'd0);

        if_write  = 1'b0;
        credit_in = 1'b1;
        step();
        step();
        if_write = 1'b1;
        if_din   = 32'hC0;
        step();
        chk("sim_count", 64'(credit_count), 64'd2);
        chk("sim_data", 64'(link_data), 64'hC0);

        if_write = 1'b0;
        step();
        step();
        credit_in = 1'b0;
        chk("refill", 64'(credit_count), 64'd4);
        if_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_din = 32'hD0 + 32'(i);
            step();
        end
        if_write = 1'b0;
        flush    = 1'b1;
        step();
        chk("flush_full_n", 64'(if_full_n), 64'd0);
        chk("flush_count", 64'(credit_count), 64'd1);
        for (int i = 0; i < 5; i++) begin
            credit_in = (i % 2 == 0);
            step();
        end
        credit_in = 1'b0;
        chk("drain_count", 64'(credit_count), 64'd4);
        chk("drain_done0", 64'(flush_done), 64'd0);
        step();
        chk("drain_done1", 64'(flush_done), 64'd1);
        flush = 1'b0;
        step();
        chk("resume_done", 64'(flush_done), 64'd0);
        chk("resume_full_n", 64'(if_full_n), 64'd1);

        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        chk("over_count", 64'(credit_count), 64'd4);
        chk("over_err", 64'(credit_err), 64'(CHK));
        step();
        chk("over_sticky", 64'(credit_err), 64'(CHK));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("err_cleared", 64'(credit_err), 64'd0);

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if_write    = ($urandom % 4) != 0;
            if_write_ce = ($urandom % 5) != 0;
            if_din      = $urandom;
            if (m_cred < CR) credit_in = ($urandom % 3) == 0;
            else credit_in = ($urandom % 40) == 0;
            if (hold > 0) begin
                hold--;
                if (hold == 0) flush = 1'b0;
            end else if (($urandom % 25) == 0) begin
                flush = 1'b1;
                hold  = $urandom_range(1, 15);
            end
            reset = ($urandom % 600) == 0;
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
